pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS CPU. It drives the write-enable and clear inputs of the PC and the IF/ID and ID/EX pipeline registers. It detects load-use hazards, flushes on taken branches and jumps, and gates all pipeline advance through a debug-unit run/step state machine. It sits between the decode/execute stages and the pipeline registers, beside the DBU.

## Interface
- `CNT_W`, default 16: width of the saturating stall counter.
- `clk  in  1`: CPU clock; all state updates on its rising edge.
- `rst  in  1`: asynchronous reset, active-low (0 = reset).
- `id_op  in  6`: opcode of the instruction held in IF/ID.
- `id_rs  in  5`: rs field of the instruction held in IF/ID.
- `id_rt  in  5`: rt field of the instruction held in IF/ID.
- `id_jump  in  1`: j/jal decoded in ID.
- `ex_mem_read  in  1`: the instruction in ID/EX is a load.
- `ex_rt  in  5`: load destination register in ID/EX.
- `ex_branch_taken  in  1`: beq/bne resolved taken in EX.
- `dbg_run  in  1`: level signal; 1 = free-run.
- `dbg_step  in  1`: synchronized button level; a rising edge requests one advance.
- `pc_write  out  1`: PC load enable.
- `ifid_write  out  1`: IF/ID write enable (IRWrite).
- `ifid_clear  out  1`: IF/ID synchronous clear.
- `idex_clear  out  1`: ID/EX clear, which inserts a bubble.
- `halted  out  1`: controller is in HALT.
- `stall_count  out  CNT_W`: number of load-use bubbles inserted since reset; saturates at all-ones.

## Operation
- States: HALT, RUN, STEP.
  - Reset enters HALT.
  - HALT: if `dbg_run`=1, go to RUN. Otherwise, on a `dbg_step` rising edge, go to STEP. Else stay in HALT.
  - RUN: if `dbg_run`=0, go to HALT. Else stay in RUN.
  - STEP: go to HALT unconditionally after one cycle.
- Step edge detection:
  - Internal register `step_q` holds the previous `dbg_step`.
  - A rising edge is `dbg_step & ~step_q`.
  - Rising edges are ignored in RUN and STEP.
  - When `dbg_run` and a step edge coincide in HALT, `dbg_run` wins.
- HALT (freeze): `pc_write`=`ifid_write`=`ifid_clear`=`idex_clear`=0.
- Advance cycle (state RUN or STEP): hazard outputs are combinational, evaluated in priority order:
  1. `ex_branch_taken`: `pc_write`=1, `ifid_write`=1, `ifid_clear`=1, `idex_clear`=1.
  2. Load-use: `pc_write`=0, `ifid_write`=0, `ifid_clear`=0, `idex_clear`=1. `stall_count` increments at the clock edge.
  3. `id_jump`: `pc_write`=1, `ifid_write`=1, `ifid_clear`=1, `idex_clear`=0.
  4. None of the above: `pc_write`=1, `ifid_write`=1, both clears 0.
- Load-use condition:
  - `ex_mem_read`=1, `ex_rt`≠0, and either:
    - `id_rs`==`ex_rt`, or
    - `id_rt`==`ex_rt` and `id_op` ∈ {0x00 R-type, 0x04 beq, 0x05 bne, 0x2B sw}.
  - A match on rt with any other opcode (e.g. lw 0x23, addi 0x08) is not a hazard.
- In STEP, a load-use stall consumes the step. The next step then advances the stalled instruction.
- `stall_count` increments only when `stall_count` != all-ones.
- `halted` = (state == HALT).

## Timing
- State, `step_q` and `stall_count` are registered. All other outputs are combinational from state and inputs, with no added latency.
- Reset values: state=HALT, `step_q`=0, `stall_count`=0.
  - Hence `pc_write`=0, `ifid_write`=0, `ifid_clear`=0, `idex_clear`=0, `halted`=1.
- Reset asserted mid-run: outputs go to the freeze values asynchronously, in the same cycle.
- `dbg_run` rising at edge N: state is RUN from edge N+1, and the first advance happens at edge N+2.
- A step edge sampled at edge N produces exactly one advance cycle, N+1 to N+2. `halted` is 0 for exactly that one cycle.
- A load-use bubble lasts one cycle. On the next cycle the load is in MEM, the comparison no longer matches, and the pipeline advances.
- `ex_branch_taken` together with a load-use match: the branch wins, and no stall is counted.

## Structure
- Shared package `pipe_pkg`:
  - state enum `ctrl_state_t` {HALT, RUN, STEP};
  - opcode constants `OP_RTYPE`, `OP_BEQ`, `OP_BNE`, `OP_SW`, `OP_LW`, `OP_J`, `OP_JAL`.
- One combinational sub-module, `load_use_detect`, with inputs (`id_op`, `id_rs`, `id_rt`, `ex_mem_read`, `ex_rt`) and output `hazard`. The top module holds the FSM, the edge detector, the counter and the output priority mux.

## Test plan
- Reset, then `dbg_run`=0 for 10 cycles → `halted`=1, all enables 0, `stall_count`=0.
- Reset, `dbg_run`=1, no hazards → from the third cycle on, `pc_write`=`ifid_write`=1 and both clears 0, continuously.
- RUN; `ex_mem_read`=1, `ex_rt`=8, `id_op`=0, `id_rs`=8 for one cycle → `pc_write`=0, `ifid_write`=0, `idex_clear`=1; `stall_count` goes 0→1. Same inputs with `ex_rt`=0 → no stall.
- RUN; load-use match with `ex_branch_taken`=1 in the same cycle → `ifid_clear`=`idex_clear`=1, `pc_write`=1, `stall_count` unchanged. `id_jump`=1 alone → `ifid_clear`=1, `idex_clear`=0.
- HALT; hold `dbg_step` high for 5 cycles → exactly one cycle with `pc_write`=1, then `halted`=1 again. A second rising edge gives a second single advance.
- RUN; assert `rst`=0 mid-cycle → `pc_write` drops to 0 immediately; after release the controller is in HALT with `stall_count`=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and MIPS opcode constants for the pipeline sequencing controller.
package pipe_pkg;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } ctrl_state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    // Opcodes whose rt field is a source operand read in ID/EX.
    function automatic logic reads_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode/execute status in, pipeline-register controls out; slave side is the controller.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [5:0]       id_op;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_jump;
    logic             ex_mem_read;
    logic [4:0]       ex_rt;
    logic             ex_branch_taken;
    logic             dbg_run;
    logic             dbg_step;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_clear;
    logic             idex_clear;
    logic             halted;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_op, id_rs, id_rt, id_jump, ex_mem_read, ex_rt, ex_branch_taken,
               dbg_run, dbg_step,
        input  pc_write, ifid_write, ifid_clear, idex_clear, halted, stall_count
    );

    modport slave (
        input  id_op, id_rs, id_rt, id_jump, ex_mem_read, ex_rt, ex_branch_taken,
               dbg_run, dbg_step,
        output pc_write, ifid_write, ifid_clear, idex_clear, halted, stall_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard detector: load in ID/EX feeding a source of the IF/ID instruction.
module load_use_detect
    import pipe_pkg::*;
(
    input  logic [5:0] id_op,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    output logic       hazard
);
    logic w_rs_match;
    logic w_rt_match;

    always_comb begin
        w_rs_match = (id_rs == ex_rt);
        w_rt_match = (id_rt == ex_rt) && reads_rt(id_op);
        // $zero never carries a loaded value, so it never stalls.
        hazard     = ex_mem_read && (ex_rt != 5'd0) && (w_rs_match || w_rt_match);
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: debug run/step FSM gating branch flush, load-use stall and jump flush.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  bus
);
    ctrl_state_t      r_state;
    ctrl_state_t      w_next_state;
    logic             r_step_q;
    logic [CNT_W-1:0] r_stall_count;

    logic w_step_edge;
    logic w_hazard;
    logic w_advance;
    logic w_stall;
    logic w_pc_write;
    logic w_ifid_write;
    logic w_ifid_clear;
    logic w_idex_clear;

    load_use_detect u_load_use_detect (
        .id_op       (bus.id_op),
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .ex_mem_read (bus.ex_mem_read),
        .ex_rt       (bus.ex_rt),
        .hazard      (w_hazard)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= HALT;
            r_step_q      <= 1'b0;
            r_stall_count <= '0;
        end else begin
            r_state  <= w_next_state;
            r_step_q <= bus.dbg_step;
            if (w_stall && (r_stall_count != '1))
                r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_step_edge  = bus.dbg_step & ~r_step_q;
        unique case (r_state)
            HALT: begin
                if (bus.dbg_run)
                    w_next_state = RUN;
                else if (w_step_edge)
                    w_next_state = STEP;
            end
            RUN:     if (!bus.dbg_run) w_next_state = HALT;
            STEP:    w_next_state = HALT;
            default: w_next_state = HALT;
        endcase
    end

    always_comb begin
        w_advance    = (r_state == RUN) || (r_state == STEP);
        w_stall      = 1'b0;
        w_pc_write   = 1'b0;
        w_ifid_write = 1'b0;
        w_ifid_clear = 1'b0;
        w_idex_clear = 1'b0;
        // Branch flush outranks the stall, so a squashed load-use is never counted.
        if (w_advance) begin
            if (bus.ex_branch_taken) begin
                w_pc_write   = 1'b1;
                w_ifid_write = 1'b1;
                w_ifid_clear = 1'b1;
                w_idex_clear = 1'b1;
            end else if (w_hazard) begin
                w_stall      = 1'b1;
                w_idex_clear = 1'b1;
            end else if (bus.id_jump) begin
                w_pc_write   = 1'b1;
                w_ifid_write = 1'b1;
                w_ifid_clear = 1'b1;
            end else begin
                w_pc_write   = 1'b1;
                w_ifid_write = 1'b1;
            end
        end
    end

    assign bus.pc_write    = w_pc_write;
    assign bus.ifid_write  = w_ifid_write;
    assign bus.ifid_clear  = w_ifid_clear;
    assign bus.idex_clear  = w_idex_clear;
    assign bus.halted      = (r_state == HALT);
    assign bus.stall_count = r_stall_count;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table, step/reset/saturation sequences,
// and randomized traffic compared against a rule-level reference model.
module tb_pipe_hazard_ctrl;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(16)) bus ();
    pipe_hazard_ctrl_if #(.CNT_W(2))  bus2 ();

    pipe_hazard_ctrl #(.CNT_W(16)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    pipe_hazard_ctrl #(.CNT_W(2))  u_sat (.clk(clk), .rst(rst), .bus(bus2));

    int unsigned total = 0;
    int unsigned bad   = 0;

    typedef struct {
        logic       run;
        logic       step;
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       jump;
        logic       mr;
        logic [4:0] exrt;
        logic       br;
        logic [3:0] exp_ctl;   // {pc_write, ifid_write, ifid_clear, idex_clear}
        logic       exp_halt;
        int unsigned exp_cnt;
    } vec_t;

    vec_t tbl [25];

    // Reference model state: free-running, one-shot advance pending, last step level, stalls.
    bit          m_free;
    bit          m_single;
    bit          m_prev;
    int unsigned m_cnt;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic run, input logic step, input logic [5:0] op,
                                input logic [4:0] rs, input logic [4:0] rt, input logic jump,
                                input logic mr, input logic [4:0] exrt, input logic br,
                                input logic [3:0] ctl, input logic halt, input int unsigned cnt);
        vec_t v;
        v.run = run; v.step = step; v.op = op; v.rs = rs; v.rt = rt; v.jump = jump;
        v.mr = mr; v.exrt = exrt; v.br = br; v.exp_ctl = ctl; v.exp_halt = halt; v.exp_cnt = cnt;
        return v;
    endfunction

    task automatic set_in(input logic run, input logic step, input logic [5:0] op,
                          input logic [4:0] rs, input logic [4:0] rt, input logic jump,
                          input logic mr, input logic [4:0] exrt, input logic br);
        bus.dbg_run = run; bus.dbg_step = step; bus.id_op = op; bus.id_rs = rs;
        bus.id_rt = rt; bus.id_jump = jump; bus.ex_mem_read = mr; bus.ex_rt = exrt;
        bus.ex_branch_taken = br;
    endtask

    task automatic set_in2(input logic run, input logic mr, input logic [4:0] rs, input logic [4:0] exrt);
        bus2.dbg_run = run; bus2.dbg_step = 1'b0; bus2.id_op = 6'h00; bus2.id_rs = rs;
        bus2.id_rt = 5'd0; bus2.id_jump = 1'b0; bus2.ex_mem_read = mr; bus2.ex_rt = exrt;
        bus2.ex_branch_taken = 1'b0;
    endtask

    function automatic logic [3:0] ctl_now();
        return {bus.pc_write, bus.ifid_write, bus.ifid_clear, bus.idex_clear};
    endfunction

    function automatic bit m_hazard();
        bit rt_src;
        rt_src = bus.id_op inside {6'h00, 6'h04, 6'h05, 6'h2B};
        return bus.ex_mem_read && (bus.ex_rt != 0) &&
               ((bus.id_rs == bus.ex_rt) || (rt_src && (bus.id_rt == bus.ex_rt)));
    endfunction

    task automatic model_reset();
        m_free = 0; m_single = 0; m_prev = 0; m_cnt = 0;
    endtask

    task automatic model_expect(output logic [3:0] ctl, output logic halt);
        halt = !(m_free || m_single);
        if (halt)                     ctl = 4'b0000;
        else if (bus.ex_branch_taken) ctl = 4'b1111;
        else if (m_hazard())          ctl = 4'b0001;
        else if (bus.id_jump)         ctl = 4'b1110;
        else                          ctl = 4'b1100;
    endtask

    task automatic model_clock();
        bit stepped;
        if ((m_free || m_single) && !bus.ex_branch_taken && m_hazard() && m_cnt != 65535)
            m_cnt++;
        stepped = bus.dbg_step && !m_prev;
        if (m_single) begin
            m_single = 0;
            m_free   = 0;
        end else if (m_free) begin
            m_free = bus.dbg_run;
        end else begin
            m_free   = bus.dbg_run;
            m_single = !bus.dbg_run && stepped;
        end
        m_prev = bus.dbg_step;
    endtask

    // Check outputs against the model mid-cycle, then advance model and clock.
    task automatic model_cycle(input string nm);
        logic [3:0] ectl;
        logic       ehalt;
        #4;
        model_expect(ectl, ehalt);
        chk({nm, "_ctl"}, 32'(ctl_now()), 32'(ectl));
        chk({nm, "_halted"}, 32'(bus.halted), 32'(ehalt));
        chk({nm, "_stall_count"}, 32'(bus.stall_count), m_cnt);
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        set_in(0, 0, 6'h00, 0, 0, 0, 0, 0, 0);
        set_in2(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        int unsigned adv;
        int unsigned nh;
        logic [5:0] ops [7];

        ops = '{6'h00, 6'h04, 6'h05, 6'h2B, 6'h23, 6'h08, 6'h02};

        tbl[0]  = mk(0,0,6'h00,0,0,0,0,0,0, 4'b0000,1,0);
        tbl[1]  = mk(1,0,6'h00,0,0,0,0,0,0, 4'b0000,1,0);
        tbl[2]  = mk(1,0,6'h00,1,2,0,0,0,0, 4'b1100,0,0);
        tbl[3]  = mk(1,0,6'h00,8,3,0,1,8,0, 4'b0001,0,0);
        tbl[4]  = mk(1,0,6'h00,1,2,0,0,0,0, 4'b1100,0,1);
        tbl[5]  = mk(1,0,6'h00,0,0,0,1,0,0, 4'b1100,0,1);
        tbl[6]  = mk(1,0,6'h00,8,3,0,1,8,1, 4'b1111,0,1);
        tbl[7]  = mk(1,0,6'h02,1,2,1,0,0,0, 4'b1110,0,1);
        tbl[8]  = mk(1,0,6'h23,1,9,0,1,9,0, 4'b1100,0,1);
        tbl[9]  = mk(1,0,6'h2B,1,9,0,1,9,0, 4'b0001,0,1);
        tbl[10] = mk(1,0,6'h08,1,9,0,1,9,0, 4'b1100,0,2);
        tbl[11] = mk(0,0,6'h04,1,9,0,1,9,0, 4'b0001,0,2);
        tbl[12] = mk(0,0,6'h05,1,9,0,1,9,0, 4'b0000,1,3);
        tbl[13] = mk(0,1,6'h00,0,0,0,0,0,0, 4'b0000,1,3);
        tbl[14] = mk(0,1,6'h00,7,0,0,1,7,0, 4'b0001,0,3);
        tbl[15] = mk(0,1,6'h00,0,0,0,0,0,0, 4'b0000,1,4);
        tbl[16] = mk(0,0,6'h00,0,0,0,0,0,0, 4'b0000,1,4);
        tbl[17] = mk(0,1,6'h00,0,0,0,0,0,0, 4'b0000,1,4);
        tbl[18] = mk(0,1,6'h02,1,2,1,0,0,0, 4'b1110,0,4);
        tbl[19] = mk(0,0,6'h00,0,0,0,0,0,0, 4'b0000,1,4);
        tbl[20] = mk(1,1,6'h00,0,0,0,0,0,0, 4'b0000,1,4);
        tbl[21] = mk(1,1,6'h00,0,0,0,0,0,0, 4'b1100,0,4);
        tbl[22] = mk(1,0,6'h00,0,0,0,0,0,0, 4'b1100,0,4);
        tbl[23] = mk(1,0,6'h02,8,3,1,1,8,0, 4'b0001,0,4);
        tbl[24] = mk(1,0,6'h00,0,0,0,0,0,0, 4'b1100,0,5);

        // Reset state held for 10 cycles with dbg_run low.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            #4;
            chk("idle_ctl", 32'(ctl_now()), 32'h0);
            chk("idle_halted", 32'(bus.halted), 32'h1);
            chk("idle_stall_count", 32'(bus.stall_count), 32'h0);
            @(posedge clk);
            #1;
        end

        // Directed vector table, applied back to back from HALT.
        for (int i = 0; i < 25; i++) begin
            set_in(tbl[i].run, tbl[i].step, tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].jump,
                   tbl[i].mr, tbl[i].exrt, tbl[i].br);
            #4;
            chk($sformatf("vec%0d_ctl", i), 32'(ctl_now()), 32'(tbl[i].exp_ctl));
            chk($sformatf("vec%0d_halted", i), 32'(bus.halted), 32'(tbl[i].exp_halt));
            chk($sformatf("vec%0d_stall_count", i), 32'(bus.stall_count), tbl[i].exp_cnt);
            @(posedge clk);
            #1;
        end

        // Holding dbg_step high yields exactly one advance per rising edge.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            set_in(0, 0, 6'h00, 1, 2, 0, 0, 0, 0);
            @(posedge clk);
            #1;
            adv = 0;
            nh  = 0;
            bus.dbg_step = 1'b1;
            for (int i = 0; i < 5; i++) begin
                #4;
                if (bus.pc_write) adv++;
                if (!bus.halted)  nh++;
                @(posedge clk);
                #1;
            end
            chk($sformatf("step_hold%0d_advances", r), adv, 1);
            chk($sformatf("step_hold%0d_unhalted_cycles", r), nh, 1);
            #4;
            chk($sformatf("step_hold%0d_halted_after", r), 32'(bus.halted), 32'h1);
            @(posedge clk);
            #1;
        end

        // Narrow counter saturates at all-ones instead of wrapping.
        do_reset();
        set_in2(1, 1, 5'd5, 5'd5);
        for (int k = 0; k < 7; k++) begin
            #4;
            chk($sformatf("sat_cnt_k%0d", k), 32'(bus2.stall_count),
                (k < 2) ? 0 : ((k - 1 > 3) ? 3 : k - 1));
            chk($sformatf("sat_halted_k%0d", k), 32'(bus2.halted), (k == 0) ? 1 : 0);
            @(posedge clk);
            #1;
        end
        set_in2(0, 0, 0, 0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            set_in(($urandom % 8) < 5, $urandom % 2, ops[$urandom % 7], 5'($urandom % 4),
                   5'($urandom % 4), ($urandom % 4) == 0, $urandom % 2, 5'($urandom % 4),
                   ($urandom % 5) == 0);
            model_cycle("rand");
        end

        // Reset asserted mid-cycle while running with stalls recorded.
        for (int n = 0; n < 4; n++) begin
            set_in(1, 0, 6'h00, 6, 0, 0, (n >= 2), 6, 0);
            model_cycle("prerst");
        end
        rst = 1'b0;
        #1;
        chk("async_rst_pc_write", 32'(bus.pc_write), 32'h0);
        chk("async_rst_halted", 32'(bus.halted), 32'h1);
        chk("async_rst_stall_count", 32'(bus.stall_count), 32'h0);
        model_reset();
        #2;
        rst = 1'b1;
        set_in(0, 0, 6'h00, 0, 0, 0, 0, 0, 0);
        #1;
        chk("post_rst_halted", 32'(bus.halted), 32'h1);
        @(posedge clk);
        #1;
        for (int n = 0; n < 3; n++) model_cycle("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
